// File: rtl/nes_pad_pkg.sv
// Shared NES pad definitions: button bit positions, frame width, protocol FSM states.
// Also used by the on-chip NES reader so both ends agree on bit order.
// nes_wire_bits() maps a pressed=1 button vector to the active-low serial order.
package nes_pad_pkg;

  localparam int NES_BITS   = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_e;

  // Wire-level image of the buttons: bit n is shifted out n-th, 0 = pressed.
  function automatic logic [NES_BITS-1:0] nes_wire_bits(input logic [NES_BITS-1:0] btn);
    logic [NES_BITS-1:0] w;
    w             = '1;
    w[BTN_A]      = ~btn[BTN_A];
    w[BTN_B]      = ~btn[BTN_B];
    w[BTN_SELECT] = ~btn[BTN_SELECT];
    w[BTN_START]  = ~btn[BTN_START];
    w[BTN_UP]     = ~btn[BTN_UP];
    w[BTN_DOWN]   = ~btn[BTN_DOWN];
    w[BTN_LEFT]   = ~btn[BTN_LEFT];
    w[BTN_RIGHT]  = ~btn[BTN_RIGHT];
    return w;
  endfunction

endpackage

// File: rtl/nes_pad_responder_filter.sv
// nes_in_filter: 2-FF synchronizer, FILTER_CYCLES run-length filter, edge detect.
// Ports: clk_i/rst_i (async active-high), pin_i async input; level_o filtered level,
//        rise_o/fall_o one-cycle registered pulses issued when level_o changes.
module nes_in_filter
  #(parameter int FILTER_CYCLES = 4)
  (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
  );

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      // cnt_q counts consecutive synchronized samples disagreeing with level_q;
      // the FILTER_CYCLES-th such sample flips the level.
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          fall_q  <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: emulates the pad-side 4021 shift register of the NES pad protocol.
// Ports: sysclk, reset_high (async); nes_latch/nes_pulse from host; buttons (pressed=1),
//        turbo_ab; nes_data (active-low serial), frame_done pulse, bit_idx (0..8).
// Optional turbo on A/B is compiled in with macro NES_PAD_TURBO_EN.
module nes_pad_responder
  import nes_pad_pkg::*;
  #(
    parameter int FILTER_CYCLES = 4,
    parameter int TURBO_DIV     = 4
  )
  (
    input  logic                sysclk,
    input  logic                reset_high,
    input  logic                nes_latch,
    input  logic                nes_pulse,
    input  logic [NES_BITS-1:0] buttons,
    input  logic [1:0]          turbo_ab,
    output logic                nes_data,
    output logic                frame_done,
    output logic [3:0]          bit_idx
  );

  logic latch_lvl, latch_rise, latch_fall;
  logic pulse_rise, pulse_lvl_unused, pulse_fall_unused;

  nes_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_latch_filt (
    .clk_i   (sysclk),
    .rst_i   (reset_high),
    .pin_i   (nes_latch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  nes_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_pulse_filt (
    .clk_i   (sysclk),
    .rst_i   (reset_high),
    .pin_i   (nes_pulse),
    .level_o (pulse_lvl_unused),
    .rise_o  (pulse_rise),
    .fall_o  (pulse_fall_unused)
  );

  logic [NES_BITS-1:0] buttons_eff;

`ifdef NES_PAD_TURBO_EN
  localparam int TCW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [TCW-1:0] turbo_cnt_q;
  logic           turbo_phase_q;

  // Phase advances per accepted frame (latch fall), so turbo rate tracks the host poll rate.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else if (latch_fall) begin
      if (turbo_cnt_q == TCW'(TURBO_DIV - 1)) begin
        turbo_cnt_q   <= '0;
        turbo_phase_q <= ~turbo_phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + TCW'(1);
      end
    end
  end

  always_comb begin
    buttons_eff        = buttons;
    buttons_eff[BTN_A] = buttons[BTN_A] & (~turbo_ab[0] | turbo_phase_q);
    buttons_eff[BTN_B] = buttons[BTN_B] & (~turbo_ab[1] | turbo_phase_q);
  end
`else
  localparam int unused_turbo_div = TURBO_DIV;
  logic unused_turbo_ab;
  assign unused_turbo_ab = ^turbo_ab;
  assign buttons_eff     = buttons;
`endif

  nes_state_e          state_q;
  logic [NES_BITS-1:0] sr_q;
  logic                frame_done_q;
  logic [3:0]          bit_idx_q;
  logic [NES_BITS-1:0] load_val;

  assign load_val = nes_wire_bits(buttons_eff);

  // sr_q[0] drives the pin directly; every non-shifting state keeps sr_q all-ones so the
  // line idles released.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      state_q      <= IDLE;
      sr_q         <= '1;
      frame_done_q <= 1'b0;
      bit_idx_q    <= 4'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sr_q <= '1;
          if (latch_lvl) state_q <= LOAD;
        end
        LOAD: begin
          // Keep the snapshot taken on the last load cycle when latch drops.
          if (latch_fall) begin
            state_q <= SHIFT;
          end else begin
            sr_q      <= load_val;
            bit_idx_q <= 4'd0;
          end
        end
        SHIFT: begin
          // Latch has priority: a reassert aborts the frame and drops a coincident pulse.
          if (latch_rise) begin
            state_q   <= LOAD;
            sr_q      <= load_val;
            bit_idx_q <= 4'd0;
          end else if (pulse_rise) begin
            sr_q      <= {1'b1, sr_q[NES_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == 4'(NES_BITS - 1)) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          sr_q <= '1;
          if (latch_rise) state_q <= LOAD;
        end
        default: begin
          state_q <= IDLE;
          sr_q    <= '1;
        end
      endcase
    end
  end

  assign nes_data   = sr_q[0];
  assign frame_done = frame_done_q;
  assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: reset, full frame, pin latency, glitch rejection,
// abort, latch/pulse collision, async reset, and turbo (when NES_PAD_TURBO_EN is defined).
module tb_nes_pad_responder;

  logic       sysclk;
  logic       reset_high;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic [1:0] turbo_ab;
  logic       nes_data;
  logic       frame_done;
  logic [3:0] bit_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  logic [7:0] exp_seq;
  logic [7:0] turbo_exp;

  nes_pad_responder #(.FILTER_CYCLES(4), .TURBO_DIV(2)) dut (
    .sysclk     (sysclk),
    .reset_high (reset_high),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .turbo_ab   (turbo_ab),
    .nes_data   (nes_data),
    .frame_done (frame_done),
    .bit_idx    (bit_idx)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // frame_done pulses seen, sampled 1 ns after each edge
  always @(posedge sysclk) begin
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then move 2 ns past the edge to drive inputs.
  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic pulse(input int hi, input int lo);
    nes_pulse = 1'b1;
    cyc(hi);
    nes_pulse = 1'b0;
    cyc(lo);
  endtask

  initial begin
    reset_high = 1'b1;
    nes_latch  = 1'b0;
    nes_pulse  = 1'b0;
    buttons    = 8'h00;
    turbo_ab   = 2'b00;
    exp_seq    = 8'b1111_1010;   // nes_data before pulse i = bit i: 0,1,0,1,1,1,1,1
    turbo_exp  = 8'b0011_0011;   // frame f: R,R,P,P,R,R,P,P (1 = released)

    // Reset values
    cyc(3);
    @(negedge sysclk);
    check("rst_data",  {7'd0, nes_data},   8'd1);
    check("rst_done",  {7'd0, frame_done}, 8'd0);
    check("rst_idx",   {4'd0, bit_idx},    8'd0);
    cyc(1);
    reset_high = 1'b0;
    cyc(5);

    // Pulse with latch low in IDLE is ignored
    pulse(20, 20);
    @(negedge sysclk);
    check("idle_pulse_data", {7'd0, nes_data}, 8'd1);
    check("idle_pulse_idx",  {4'd0, bit_idx},  8'd0);

    // Basic frame: A and Select pressed, 12 us latch, 6 us pulses
    cyc(1);
    buttons   = 8'b0000_0101;
    nes_latch = 1'b1;
    cyc(1200);
    nes_latch = 1'b0;
    cyc(20);
    buttons   = 8'hFF;           // change during SHIFT must not affect the frame
    @(negedge sysclk);
    check("frame_load_data", {7'd0, nes_data}, {7'd0, exp_seq[0]});
    check("frame_load_idx",  {4'd0, bit_idx},  8'd0);

    // First pulse doubles as pin-to-output latency check: 7 cycles exactly
    cyc(1);
    nes_pulse = 1'b1;
    repeat (6) @(posedge sysclk);
    @(negedge sysclk);
    check("latency_6cyc", {7'd0, nes_data}, 8'd0);
    @(posedge sysclk);
    @(negedge sysclk);
    check("latency_7cyc", {7'd0, nes_data}, 8'd1);
    cyc(293);
    nes_pulse = 1'b0;
    cyc(300);

    for (int i = 1; i < 8; i++) begin
      @(negedge sysclk);
      check("frame_bit", {7'd0, nes_data}, {7'd0, exp_seq[i]});
      check("frame_idx", {4'd0, bit_idx},  8'(i));
      pulse(300, 300);
    end
    @(negedge sysclk);
    check("frame_done_cnt", 8'(fd_cnt),     8'd1);
    check("frame_end_idx",  {4'd0, bit_idx}, 8'd8);
    check("frame_end_data", {7'd0, nes_data}, 8'd1);

    // 9th pulse: released line, bit_idx saturates
    pulse(300, 300);
    @(negedge sysclk);
    check("ninth_data", {7'd0, nes_data}, 8'd1);
    check("ninth_idx",  {4'd0, bit_idx},  8'd8);
    check("ninth_done", 8'(fd_cnt),       8'd1);

    // New frame from DONE, B pressed
    buttons   = 8'b0000_0010;
    nes_latch = 1'b1;
    cyc(20);
    nes_latch = 1'b0;
    cyc(20);
    @(negedge sysclk);
    check("f2_load_data", {7'd0, nes_data}, 8'd1);
    check("f2_load_idx",  {4'd0, bit_idx},  8'd0);
    pulse(20, 20);
    @(negedge sysclk);
    check("f2_b_data", {7'd0, nes_data}, 8'd0);
    check("f2_b_idx",  {4'd0, bit_idx},  8'd1);

    // 3-cycle latch spike during SHIFT: rejected
    nes_latch = 1'b1;
    cyc(3);
    nes_latch = 1'b0;
    cyc(20);
    @(negedge sysclk);
    check("latch_glitch_idx",  {4'd0, bit_idx},  8'd1);
    check("latch_glitch_data", {7'd0, nes_data}, 8'd0);

    // 3-cycle pulse spike during SHIFT: rejected
    pulse(3, 20);
    @(negedge sysclk);
    check("pulse_glitch_idx",  {4'd0, bit_idx},  8'd1);
    check("pulse_glitch_data", {7'd0, nes_data}, 8'd0);

    // Abort after 3 pulses
    pulse(20, 20);
    pulse(20, 20);
    buttons = 8'b0000_0001;
    @(negedge sysclk);
    check("pre_abort_idx",  {4'd0, bit_idx},  8'd3);
    check("pre_abort_data", {7'd0, nes_data}, 8'd1);
    nes_latch = 1'b1;
    cyc(20);
    @(negedge sysclk);
    check("abort_idx",  {4'd0, bit_idx},  8'd0);
    check("abort_data", {7'd0, nes_data}, 8'd0);
    check("abort_done", 8'(fd_cnt),       8'd1);
    buttons = 8'b0000_0011;
    cyc(10);
    nes_latch = 1'b0;
    cyc(20);

    // Latch and pulse accepted in the same cycle: latch wins
    pulse(20, 20);
    @(negedge sysclk);
    check("pre_collide_idx", {4'd0, bit_idx}, 8'd1);
    nes_latch = 1'b1;
    nes_pulse = 1'b1;
    cyc(20);
    nes_pulse = 1'b0;
    cyc(10);
    @(negedge sysclk);
    check("collide_idx",  {4'd0, bit_idx},  8'd0);
    check("collide_data", {7'd0, nes_data}, 8'd0);
    nes_latch = 1'b0;
    cyc(20);

    // Async reset mid-SHIFT
    pulse(20, 20);
    @(negedge sysclk);
    check("pre_reset_idx",  {4'd0, bit_idx},  8'd1);
    check("pre_reset_data", {7'd0, nes_data}, 8'd0);
    @(posedge sysclk);
    #3;
    reset_high = 1'b1;
    #1;
    check("async_rst_data", {7'd0, nes_data},   8'd1);
    check("async_rst_idx",  {4'd0, bit_idx},    8'd0);
    check("async_rst_done", {7'd0, frame_done}, 8'd0);
    cyc(3);
    reset_high = 1'b0;
    cyc(5);

`ifdef NES_PAD_TURBO_EN
    // Turbo on A, TURBO_DIV = 2, starting from phase 0 after reset
    buttons  = 8'b0000_0001;
    turbo_ab = 2'b01;
    for (int f = 0; f < 8; f++) begin
      nes_latch = 1'b1;
      cyc(20);
      nes_latch = 1'b0;
      cyc(20);
      @(negedge sysclk);
      check("turbo_frame", {7'd0, nes_data}, {7'd0, turbo_exp[f]});
    end
`else
    // Without turbo compiled in, turbo_ab has no effect
    buttons  = 8'b0000_0001;
    turbo_ab = 2'b01;
    for (int f = 0; f < 2; f++) begin
      nes_latch = 1'b1;
      cyc(20);
      nes_latch = 1'b0;
      cyc(20);
      @(negedge sysclk);
      check("no_turbo_frame", {7'd0, nes_data}, 8'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
